// File: rtl/bc_pkg.sv
// bc_pkg: shared encodings and default sizes for the decode-stage PDR queue.
package bc_pkg;
  typedef enum logic [1:0] {
    BC_DI_DM   = 2'b00,
    BC_DI_PDR  = 2'b01,
    BC_DI_IMM  = 2'b10,
    BC_DI_ZERO = 2'b11
  } bc_di_e;
  localparam int BC_DW    = 16;
  localparam int BC_NSRC  = 4;
  localparam int BC_DEPTH = 4;
endpackage

// File: rtl/bc_pdr_queue_if.sv
// bc_pdr_queue_if: sequencer/datapath side bundle of the PDR queue.
interface bc_pdr_queue_if #(
  parameter int DW    = 16,
  parameter int NSRC  = 4,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(NSRC),
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic [NSRC*DW-1:0] bc_src_dt;
  logic [SW-1:0]      ps_bc_drr_sclt;
  logic               ps_bc_drr_wen;
  logic               ps_bc_di_pop;
  logic [1:0]         ps_bc_di_sclt;
  logic [DW-1:0]      dm_bc_dt;
  logic [DW-1:0]      ps_bc_immdt;
  logic               ps_bc_err_clr;
  logic [DW-1:0]      bc_dt;
  logic               bc_pdr_empty;
  logic               bc_pdr_full;
  logic [CW-1:0]      bc_pdr_cnt;
  logic               bc_ovf_err;
  logic               bc_udf_err;
  modport master (
    output bc_src_dt, ps_bc_drr_sclt, ps_bc_drr_wen, ps_bc_di_pop, ps_bc_di_sclt,
           dm_bc_dt, ps_bc_immdt, ps_bc_err_clr,
    input  bc_dt, bc_pdr_empty, bc_pdr_full, bc_pdr_cnt, bc_ovf_err, bc_udf_err
  );
  modport slave (
    input  bc_src_dt, ps_bc_drr_sclt, ps_bc_drr_wen, ps_bc_di_pop, ps_bc_di_sclt,
           dm_bc_dt, ps_bc_immdt, ps_bc_err_clr,
    output bc_dt, bc_pdr_empty, bc_pdr_full, bc_pdr_cnt, bc_ovf_err, bc_udf_err
  );
endinterface

// File: rtl/bc_pdr_fifo.sv
// bc_pdr_fifo: DEPTH-entry queue with occupancy count and refused-push/empty-pop events.
module bc_pdr_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_dcd,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          udf
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(DEPTH);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & ~push_ok;
  assign udf     = pop & empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_dcd)
    if (rst_n && push_ok) mem[wr_ptr] <= wdata;
  // power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk_dcd) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      cnt    <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/bc_pdr_queue.sv
// bc_pdr_queue: selects a DRR source into the PDR queue and drives bc_dt from dm, queue head or immediate.
module bc_pdr_queue
  import bc_pkg::*;
#(
  parameter int DW    = BC_DW,
  parameter int NSRC  = BC_NSRC,
  parameter int DEPTH = BC_DEPTH
) (
  input logic           clk_dcd,
  input logic           rst_n,
  bc_pdr_queue_if.slave bus
);
  localparam int SW = $clog2(NSRC);
  localparam int PW = (1 << SW) * DW;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PW-1:0] src_pad;
  logic [DW-1:0] push_dt, head;
  logic [CW-1:0] cnt;
  logic          empty, full, ovf, udf, ovf_err, udf_err;
  // zero-padding to a full power-of-two span makes out-of-range selects push zero
  assign src_pad = PW'(bus.bc_src_dt);
  assign push_dt = src_pad[bus.ps_bc_drr_sclt*DW +: DW];
  bc_pdr_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_dcd (clk_dcd),
    .rst_n   (rst_n),
    .push    (bus.ps_bc_drr_wen),
    .pop     (bus.ps_bc_di_pop),
    .wdata   (push_dt),
    .rdata   (head),
    .empty   (empty),
    .full    (full),
    .cnt     (cnt),
    .ovf     (ovf),
    .udf     (udf)
  );
  always_ff @(posedge clk_dcd) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf | (ovf_err & ~bus.ps_bc_err_clr);
      udf_err <= udf | (udf_err & ~bus.ps_bc_err_clr);
    end
  end
  assign bus.bc_dt = bus.ps_bc_di_sclt == BC_DI_DM  ? bus.dm_bc_dt :
                     bus.ps_bc_di_sclt == BC_DI_PDR ? head :
                     bus.ps_bc_di_sclt == BC_DI_IMM ? bus.ps_bc_immdt : '0;
  assign bus.bc_pdr_empty = empty;
  assign bus.bc_pdr_full  = full;
  assign bus.bc_pdr_cnt   = cnt;
  assign bus.bc_ovf_err   = ovf_err;
  assign bus.bc_udf_err   = udf_err;
endmodule

// File: tb/tb_bc_pdr_queue.sv
// tb_bc_pdr_queue: directed and random checks of bc_pdr_queue against a queue-based model.
module tb_bc_pdr_queue;
  logic clk_dcd = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_dcd = ~clk_dcd;
  bc_pdr_queue_if #(.DW(16), .NSRC(4), .DEPTH(4)) b4 ();
  bc_pdr_queue_if #(.DW(16), .NSRC(3), .DEPTH(4)) b3 ();
  bc_pdr_queue #(.DW(16), .NSRC(4), .DEPTH(4)) dut4 (.clk_dcd(clk_dcd), .rst_n(rst_n), .bus(b4.slave));
  bc_pdr_queue #(.DW(16), .NSRC(3), .DEPTH(4)) dut3 (.clk_dcd(clk_dcd), .rst_n(rst_n), .bus(b3.slave));
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] src [4];
  logic [15:0] q [$];
  logic m_ovf, m_udf;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [15:0] exp_dt();
    case (b4.ps_bc_di_sclt)
      2'b00:   return b4.dm_bc_dt;
      2'b01:   return q.size() > 0 ? q[0] : 16'h0;
      2'b10:   return b4.ps_bc_immdt;
      default: return 16'h0;
    endcase
  endfunction
  task automatic cyc();
    logic pop_ok, push_ok, ovf_e, udf_e;
    b4.bc_src_dt = {src[3], src[2], src[1], src[0]};
    #1;
    chk("bc_dt", 32'(b4.bc_dt), 32'(exp_dt()));
    chk("empty", 32'(b4.bc_pdr_empty), 32'(q.size() == 0));
    chk("full", 32'(b4.bc_pdr_full), 32'(q.size() == 4));
    chk("cnt", 32'(b4.bc_pdr_cnt), 32'(q.size()));
    chk("ovf_err", 32'(b4.bc_ovf_err), 32'(m_ovf));
    chk("udf_err", 32'(b4.bc_udf_err), 32'(m_udf));
    @(posedge clk_dcd);
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pop_ok  = b4.ps_bc_di_pop && q.size() > 0;
      push_ok = b4.ps_bc_drr_wen && (q.size() < 4 || pop_ok);
      udf_e   = b4.ps_bc_di_pop && q.size() == 0;
      ovf_e   = b4.ps_bc_drr_wen && !push_ok;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(src[b4.ps_bc_drr_sclt]);
      m_ovf = ovf_e | (m_ovf & ~b4.ps_bc_err_clr);
      m_udf = udf_e | (m_udf & ~b4.ps_bc_err_clr);
    end
    #1;
  endtask
  task automatic step(input logic [1:0] sclt, input logic wen, input logic pop,
                      input logic [1:0] di, input logic clr);
    b4.ps_bc_drr_sclt = sclt;
    b4.ps_bc_drr_wen  = wen;
    b4.ps_bc_di_pop   = pop;
    b4.ps_bc_di_sclt  = di;
    b4.ps_bc_err_clr  = clr;
    cyc();
  endtask
  initial begin
    src = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    b4.dm_bc_dt = 16'hA5A5;
    b4.ps_bc_immdt = 16'h5A5A;
    b4.ps_bc_drr_sclt = '0; b4.ps_bc_drr_wen = 0; b4.ps_bc_di_pop = 0;
    b4.ps_bc_di_sclt = 2'b01; b4.ps_bc_err_clr = 0;
    b4.bc_src_dt = {src[3], src[2], src[1], src[0]};
    b3.bc_src_dt = {16'h0333, 16'h0222, 16'h0111};
    b3.ps_bc_drr_sclt = '0; b3.ps_bc_drr_wen = 0; b3.ps_bc_di_pop = 0;
    b3.ps_bc_di_sclt = 2'b01; b3.dm_bc_dt = '0; b3.ps_bc_immdt = '0; b3.ps_bc_err_clr = 0;
    q.delete(); m_ovf = 0; m_udf = 0;
    repeat (2) @(posedge clk_dcd);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 2'b01, 0);
    step(0, 0, 0, 2'b00, 0);
    step(0, 0, 0, 2'b10, 0);
    step(0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 4; i++) step(2'(i), 1, 0, 2'b01, 0);
    step(0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 4; i++) step(2'(i), 1, 0, 2'b01, 0);
    src[0] = 16'h0055;
    step(0, 1, 0, 2'b01, 0);
    step(0, 1, 1, 2'b01, 0);
    step(0, 0, 0, 2'b01, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 2'b01, 0);
    step(0, 0, 1, 2'b01, 0);
    src[0] = 16'h1234;
    step(0, 1, 1, 2'b01, 0);
    step(0, 0, 1, 2'b01, 0);
    step(0, 0, 1, 2'b01, 1);
    step(0, 0, 0, 2'b01, 1);
    step(0, 0, 0, 2'b01, 0);
    step(1, 1, 0, 2'b01, 0);
    step(2, 1, 0, 2'b01, 0);
    rst_n = 1'b0;
    step(3, 1, 1, 2'b01, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 39) != 0;
      for (int k = 0; k < 4; k++) src[k] = 16'($urandom);
      b4.dm_bc_dt = 16'($urandom);
      b4.ps_bc_immdt = 16'($urandom);
      step(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;
    step(0, 0, 0, 2'b01, 0);
    b3.ps_bc_drr_sclt = 2'd3; b3.ps_bc_drr_wen = 1;
    @(posedge clk_dcd); #1;
    chk("n3_cnt_after_push", 32'(b3.bc_pdr_cnt), 32'd1);
    chk("n3_zero_push", 32'(b3.bc_dt), 32'h0);
    b3.ps_bc_drr_wen = 0; b3.ps_bc_di_pop = 1;
    @(posedge clk_dcd); #1;
    chk("n3_cnt_after_pop", 32'(b3.bc_pdr_cnt), 32'd0);
    b3.ps_bc_di_pop = 0; b3.ps_bc_drr_sclt = 2'd2; b3.ps_bc_drr_wen = 1;
    @(posedge clk_dcd); #1;
    b3.ps_bc_drr_wen = 0;
    chk("n3_src2", 32'(b3.bc_dt), 32'h0333);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bc_pdr_queue.md
# bc_pdr_queue

Parametrised successor to the decode-stage bus connect. It selects one of NSRC producer buses into a DEPTH-entry program-data-register (PDR) queue, then drives the shared data bus `bc_dt` from data memory, the queue head, or the immediate. The single-register PDR stage is replaced by a FIFO with push/pop control, full/empty/count status and sticky overflow/underflow flags. It sits between the sequencer (`ps_*`) and the datapath.

## Interface
- DW, 16, data width of every bus
- NSRC, 4, number of DRR source buses (≥2)
- SW, $clog2(NSRC), DRR select width
- DEPTH, 4, queue entries (power of 2, ≥2)
- CW, $clog2(DEPTH)+1, occupancy count width

- clk_dcd  in  1  decode clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- bc_src_dt  in  NSRC*DW  packed DRR sources; source k at [k*DW +: DW]
- ps_bc_drr_sclt  in  SW  DRR source select
- ps_bc_drr_wen  in  1  push request
- ps_bc_di_pop  in  1  pop request
- ps_bc_di_sclt  in  2  output select: 00 dm, 01 queue head, 10 immediate, 11 zero
- dm_bc_dt  in  DW  data-memory read data
- ps_bc_immdt  in  DW  immediate data
- ps_bc_err_clr  in  1  clears sticky error flags
- bc_dt  out  DW  data bus
- bc_pdr_empty  out  1  queue empty
- bc_pdr_full  out  1  queue full
- bc_pdr_cnt  out  CW  occupancy, 0..DEPTH
- bc_ovf_err  out  1  sticky: push refused
- bc_udf_err  out  1  sticky: pop on empty

## Operation
- Push data = source[ps_bc_drr_sclt]; a select value ≥ NSRC pushes zero.
- pop_ok = ps_bc_di_pop & ~empty.
- push_ok = ps_bc_drr_wen & (~full | pop_ok). A push on full with a same-cycle pop is accepted.
- On push_ok: write mem[wr_ptr] and increment wr_ptr. On pop_ok: increment rd_ptr.
- Pointers wrap modulo DEPTH. Count is +1, −1, or unchanged when push and pop both succeed.
- Push and pop on empty: the push is accepted, the pop is ignored, and bc_udf_err sets.
- Push on full without pop: data is dropped, state is unchanged, and bc_ovf_err sets.
- Error flags are sticky until ps_bc_err_clr. If clear and a new error occur in the same cycle, set wins.
- bc_dt is a combinational mux on ps_bc_di_sclt. The head path reads mem[rd_ptr], forced to zero while empty.
- Pop is independent of ps_bc_di_sclt.

## Timing
- Reset (rst_n=0 at an edge) sets: pointers 0, bc_pdr_cnt 0, bc_pdr_empty 1, bc_pdr_full 0, both error flags 0. Memory is not reset. bc_dt then equals the selected non-queue input, or zero on select 01/11.
- Reset asserted mid-operation discards all queued entries at that edge; push/pop in that cycle are ignored.
- Write-to-head latency is 1 cycle: data pushed at edge N is visible on bc_dt (select 01) after edge N. There is no same-cycle bypass.
- Status outputs are registered and update at the same edge as the pointers.
- bc_dt changes combinationally with its select and data inputs within the cycle.

## Structure
- Package bc_pkg holds:
  - output select encodings BC_DI_DM=2'b00, BC_DI_PDR=2'b01, BC_DI_IMM=2'b10, BC_DI_ZERO=2'b11
  - default DW/NSRC/DEPTH constants
- Sub-module bc_pdr_fifo (DW, DEPTH): pointers, count, flags and storage.
- The top level holds the source mux, output mux and error flags.

## Test plan
- Reset, then select 01 → bc_dt=0, empty=1, cnt=0. Select 00 with dm_bc_dt=16'hA5A5 → bc_dt=16'hA5A5.
- Push sources 0..3 = 16'h0011/0022/0033/0044 on consecutive cycles → full=1 and cnt=4 after the 4th edge; 4 pops yield 0011, 0022, 0033, 0044 in order, then empty=1.
- Full queue, push 16'h0055 alone → ovf_err=1, cnt=4. Full queue, push+pop together → head advances and cnt stays 4; data 16'h0055 emerges 4 pops later (wrap-around).
- Empty queue, pop → udf_err=1. Empty queue, push 16'h1234 + pop → cnt=1, head=16'h1234.
- With udf_err set, assert err_clr with a new underflow in the same cycle → udf_err stays 1; err_clr alone next cycle → 0.
- 2 entries queued, rst_n=0 for one edge → cnt=0, empty=1, bc_dt (select 01)=0. ps_bc_drr_sclt=3 with NSRC=3 → pushes zero.
